// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with hold, shift-right,
// shift-left and parallel-load modes, plus a saturating shift counter/done flag
// for serializer / deserializer use.
// Optional build macro: USR_ROTATE_EN turns the shifts into rotates (the serial
// inputs are then ignored); the port list is the same in both builds.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic                           sin_r,
  input  logic                           sin_l,
  input  logic [WIDTH-1:0]               pin,
  output logic [WIDTH-1:0]               Q,
  output logic [WIDTH-1:0]               Qbar,
  output logic                           sout_r,
  output logic                           sout_l,
  output logic [$clog2(WIDTH+1)-1:0]     count,
  output logic                           done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;
  logic             fill_r;
  logic             fill_l;

  // Bits entering each end on a shift: serial inputs, or the opposite end when rotating
`ifdef USR_ROTATE_EN
  assign fill_r = Q[0];
  assign fill_l = Q[WIDTH-1];
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  // Shift count saturates at WIDTH so done stays high on extra shifts
  assign cnt_inc = (count == CNT_MAX) ? CNT_MAX : count + CW'(1);

  // Next-state selection by mode
  always_comb begin
    q_next   = Q;
    cnt_next = count;
    case (mode)
      MODE_HOLD: begin
        q_next   = Q;
        cnt_next = count;
      end
      MODE_SHR: begin
        q_next   = {fill_r, Q[WIDTH-1:1]};
        cnt_next = cnt_inc;
      end
      MODE_SHL: begin
        q_next   = {Q[WIDTH-2:0], fill_l};
        cnt_next = cnt_inc;
      end
      MODE_LOAD: begin
        q_next   = pin;
        cnt_next = '0;
      end
      default: begin
        q_next   = Q;
        cnt_next = count;
      end
    endcase
  end

  // State register; synchronous reset overrides any mode
  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= '0;
      count <= '0;
    end else begin
      Q     <= q_next;
      count <= cnt_next;
    end
  end

  // Decoded views of registered state, no added latency
  assign Qbar   = ~Q;
  assign sout_r = Q[0];
  assign sout_l = Q[WIDTH-1];
  assign done   = (count == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (WIDTH=4): directed vector table covering the
// documented scenarios, then randomized traffic against an arithmetic model.
// Honours USR_ROTATE_EN the same way as the design.
module tb_univ_shift_reg;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);

`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic [W-1:0]  pin = '0;
  logic [W-1:0]  Q;
  logic [W-1:0]  Qbar;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] count;
  logic          done;

  int n_vec  = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pin    (pin),
    .Q      (Q),
    .Qbar   (Qbar),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .count  (count),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [1:0]   mode;
    logic         sr;
    logic         sl;
    logic [W-1:0] pin;
    logic [W-1:0] q;      // expected Q, shift build
    logic [W-1:0] q_rot;  // expected Q, rotate build
    int           cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] m, input logic sr, input logic sl,
                     input logic [W-1:0] p, input logic [W-1:0] q, input logic [W-1:0] q_rot,
                     input int cnt);
    vec_t v;
    v.rst = rst; v.mode = m; v.sr = sr; v.sl = sl; v.pin = p;
    v.q = q; v.q_rot = q_rot; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs sampled 1 time unit after it
  task automatic apply(input logic rst, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [W-1:0] p);
    reset = rst; mode = m; sin_r = sr; sin_l = sl; pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int q, input int cnt);
    int mask;
    mask = (1 << W) - 1;
    check({tag, " Q"},      int'(Q),      q);
    check({tag, " Qbar"},   int'(Qbar),   (~q) & mask);
    check({tag, " count"},  int'(count),  cnt);
    check({tag, " done"},   int'(done),   (cnt == W) ? 1 : 0);
    check({tag, " sout_r"}, int'(sout_r), q & 1);
    check({tag, " sout_l"}, int'(sout_l), (q >> (W - 1)) & 1);
  endtask

  int mq, mc;
  int inb;
  int mask;
  logic         r_rst;
  logic [1:0]   r_mode;
  logic         r_sr, r_sl;
  logic [W-1:0] r_pin;

  initial begin
    //   rst mode sr sl pin      Q        Q(rot)   cnt
    // reset beats a load
    add(1, 2'b11, 0, 0, 4'b1010, 4'b0000, 4'b0000, 0);
    // load 1011, shift right x4 with sin_r=0
    add(0, 2'b11, 0, 0, 4'b1011, 4'b1011, 4'b1011, 0);
    add(0, 2'b01, 0, 0, 4'b0000, 4'b0101, 4'b1101, 1);
    add(0, 2'b01, 0, 0, 4'b0000, 4'b0010, 4'b1110, 2);
    add(0, 2'b01, 0, 0, 4'b0000, 4'b0001, 4'b0111, 3);
    add(0, 2'b01, 0, 0, 4'b0000, 4'b0000, 4'b1011, 4);
    // load right after done clears it, then a back-to-back load
    add(0, 2'b11, 0, 0, 4'b0110, 4'b0110, 4'b0110, 0);
    add(0, 2'b11, 1, 1, 4'b1001, 4'b1001, 4'b1001, 0);
    // reset, shift-left fill 1,0,0,1, then a 5th shift past saturation
    add(1, 2'b00, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(0, 2'b10, 0, 1, 4'b0000, 4'b0001, 4'b0000, 1);
    add(0, 2'b10, 0, 0, 4'b0000, 4'b0010, 4'b0000, 2);
    add(0, 2'b10, 0, 0, 4'b0000, 4'b0100, 4'b0000, 3);
    add(0, 2'b10, 0, 1, 4'b0000, 4'b1001, 4'b0000, 4);
    add(0, 2'b10, 0, 1, 4'b0000, 4'b0011, 4'b0000, 4);
    // hold then mid-operation reset
    add(0, 2'b11, 0, 0, 4'b1100, 4'b1100, 4'b1100, 0);
    add(0, 2'b01, 1, 0, 4'b0000, 4'b1110, 4'b0110, 1);
    add(0, 2'b00, 1, 1, 4'b1111, 4'b1110, 4'b0110, 1);
    add(0, 2'b00, 0, 1, 4'b0101, 4'b1110, 4'b0110, 1);
    add(0, 2'b00, 1, 0, 4'b0011, 4'b1110, 4'b0110, 1);
    add(1, 2'b01, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0);
    // load 1000, shift right x4 with sin_r=1 (rotate returns to 1000)
    add(0, 2'b11, 0, 0, 4'b1000, 4'b1000, 4'b1000, 0);
    add(0, 2'b01, 1, 0, 4'b0000, 4'b1100, 4'b0100, 1);
    add(0, 2'b01, 1, 0, 4'b0000, 4'b1110, 4'b0010, 2);
    add(0, 2'b01, 1, 0, 4'b0000, 4'b1111, 4'b0001, 3);
    add(0, 2'b01, 1, 0, 4'b0000, 4'b1111, 4'b1000, 4);

    // directed table
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].mode, tbl[i].sr, tbl[i].sl, tbl[i].pin);
      expect_state($sformatf("vec%0d", i), int'(ROT ? tbl[i].q_rot : tbl[i].q), tbl[i].cnt);
    end

    // randomized traffic against the arithmetic model
    mask = (1 << W) - 1;
    mq = 0;
    mc = 0;
    for (int n = 0; n < 400; n++) begin
      r_rst  = (n == 0) || ($urandom_range(15) == 0);
      r_mode = 2'($urandom_range(3));
      r_sr   = 1'($urandom_range(1));
      r_sl   = 1'($urandom_range(1));
      r_pin  = W'($urandom);
      // loads are rarer so long shift runs reach saturation
      if (r_mode == 2'b11 && $urandom_range(2) != 0) r_mode = 2'($urandom_range(1, 2));
      apply(r_rst, r_mode, r_sr, r_sl, r_pin);
      if (r_rst) begin
        mq = 0;
        mc = 0;
      end else if (r_mode == 2'b01) begin
        inb = ROT ? (mq & 1) : int'(r_sr);
        mq  = (mq >> 1) | (inb << (W - 1));
        mc  = (mc < W) ? mc + 1 : W;
      end else if (r_mode == 2'b10) begin
        inb = ROT ? ((mq >> (W - 1)) & 1) : int'(r_sl);
        mq  = ((mq << 1) | inb) & mask;
        mc  = (mc < W) ? mc + 1 : W;
      end else if (r_mode == 2'b11) begin
        mq = int'(r_pin);
        mc = 0;
      end
      expect_state($sformatf("rnd%0d", n), mq, mc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
